game_ctrl: RTL and testbench

Central game sequencer for the dinosaur runner. It turns the START/PAUSE buttons, the VGA vertical sync and the dinosaur/cactus pixel overlap into one game state. From that state it drives `game_status` and the scroll `speed` consumed by the Jump, Ground, Cactus and Score blocks. It replaces ad-hoc top-level start/stop logic with an explicit FSM: frame-aligned starts, filtered collision detection and a frame-based speed ramp.

---
 rtl/game_pkg.sv | 21 ++
 rtl/game_ctrl_edge_sync.sv | 33 +++
 rtl/game_ctrl.sv | 149 ++++++++++++++
 tb/tb_game_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: state encodings, speed width and default tuning constants.
// Latency: none (declarations only). Backpressure: not applicable.
// Jump, Ground, Cactus and Score import this package alongside game_ctrl.
package game_pkg;

    localparam int SPEED_W = 4;

    localparam logic [SPEED_W-1:0] DEF_SPEED_INIT  = 4'd2;
    localparam logic [SPEED_W-1:0] DEF_SPEED_MAX   = 4'd10;
    localparam int unsigned        DEF_RAMP_FRAMES = 600;
    localparam int unsigned        DEF_HIT_CYCLES  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

endpackage

// File: rtl/game_ctrl_edge_sync.sv
// 2-flop synchronizer with rise/fall pulse outputs; reset value chosen per input.
// Latency: input edge to pulse is 2 CLK, pulse is 1 CLK wide.
// Backpressure: none, free-running.
module edge_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1 <= RST_VAL;
            sync2 <= RST_VAL;
            prev  <= RST_VAL;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;
    assign fall = ~sync2 & prev;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer FSM (IDLE/ARMED/RUN/PAUSE/OVER) with collision filter and speed ramp.
// Latency: button/vs edge to state change 3 CLK; collision ends RUN on the sampling edge.
// Backpressure: none. Optional pause support under GAME_CTRL_PAUSE_EN.
module game_ctrl
    import game_pkg::*;
#(
    parameter logic [SPEED_W-1:0] SPEED_INIT  = DEF_SPEED_INIT,
    parameter logic [SPEED_W-1:0] SPEED_MAX   = DEF_SPEED_MAX,
    parameter int unsigned        RAMP_FRAMES = DEF_RAMP_FRAMES,
    parameter int unsigned        HIT_CYCLES  = DEF_HIT_CYCLES
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               start,
    input  logic               pause,
    input  logic               vs,
    input  logic               px_dinosaur,
    input  logic               px_cactus,
    output logic               game_status,
    output logic               game_over,
    output logic [SPEED_W-1:0] speed,
    output logic [2:0]         state,
    output logic               frame_tick
);

    localparam logic [15:0] RAMP_LAST = 16'(RAMP_FRAMES - 1);
    localparam logic [7:0]  HIT_LAST  = 8'(HIT_CYCLES - 1);

    logic start_evt;
    logic pause_evt;
    logic unused_start_fall;
    logic unused_vs_rise;

    edge_sync #(.RST_VAL(1'b0)) u_start_sync (
        .CLK(CLK), .RESET_N(RESET_N), .din(start),
        .rise(start_evt), .fall(unused_start_fall)
    );

    // vs idles high, so its synchronizer resets high to avoid a tick on reset exit
    edge_sync #(.RST_VAL(1'b1)) u_vs_sync (
        .CLK(CLK), .RESET_N(RESET_N), .din(vs),
        .rise(unused_vs_rise), .fall(frame_tick)
    );

`ifdef GAME_CTRL_PAUSE_EN
    logic unused_pause_fall;
    logic pend_q;
    logic pend_d;

    edge_sync #(.RST_VAL(1'b0)) u_pause_sync (
        .CLK(CLK), .RESET_N(RESET_N), .din(pause),
        .rise(pause_evt), .fall(unused_pause_fall)
    );
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign pause_evt    = 1'b0;
`endif

    state_t             state_q, state_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [15:0]        ramp_q, ramp_d;
    logic [7:0]         hit_q, hit_d;
    logic               overlap;

    assign overlap = px_dinosaur & px_cactus;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            speed_q <= '0;
            ramp_q  <= '0;
            hit_q   <= '0;
`ifdef GAME_CTRL_PAUSE_EN
            pend_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            speed_q <= speed_d;
            ramp_q  <= ramp_d;
            hit_q   <= hit_d;
`ifdef GAME_CTRL_PAUSE_EN
            pend_q  <= pend_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        ramp_d  = ramp_q;
        hit_d   = hit_q;
`ifdef GAME_CTRL_PAUSE_EN
        pend_d  = pend_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_evt) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (frame_tick) begin
                    state_d = ST_RUN;
                    speed_d = SPEED_INIT;
                    ramp_d  = '0;
                    hit_d   = '0;
                end
            end
            ST_RUN: begin
                // a completed collision beats a coincident frame tick or pause
                if (overlap && (hit_q == HIT_LAST)) begin
                    state_d = ST_OVER;
                end else if (pause_evt) begin
                    state_d = ST_PAUSE;
                    hit_d   = '0;
                end else if (frame_tick) begin
                    hit_d = {7'd0, overlap};
                    if (ramp_q == RAMP_LAST) begin
                        ramp_d  = '0;
                        speed_d = (speed_q >= SPEED_MAX) ? SPEED_MAX : speed_q + 1'b1;
                    end else begin
                        ramp_d = ramp_q + 16'd1;
                    end
                end else if (overlap) begin
                    hit_d = hit_q + 8'd1;
                end
            end
`ifdef GAME_CTRL_PAUSE_EN
            ST_PAUSE: begin
                if (pend_q && frame_tick) begin
                    state_d = ST_RUN;
                    pend_d  = 1'b0;
                end else if (pause_evt) begin
                    pend_d = 1'b1;
                end
            end
`endif
            ST_OVER: begin
                if (start_evt) state_d = ST_ARMED;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign game_status = (state_q == ST_RUN);
    assign game_over   = (state_q == ST_OVER);
    assign speed       = (state_q == ST_IDLE) ? '0 : speed_q;
    assign state       = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed vector table, hand-written corner sequences and random
// stimulus, all compared every cycle against a frame/event-level reference model.
module tb_game_ctrl;

    localparam int P_INIT = 2;
    localparam int P_MAX  = 3;
    localparam int P_RAMP = 3;
    localparam int P_HIT  = 4;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_RUN   = 2;
    localparam int M_PAUSE = 3;
    localparam int M_OVER  = 4;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       vs = 1'b1;
    logic       px_dinosaur = 1'b0;
    logic       px_cactus = 1'b0;
    logic       game_status;
    logic       game_over;
    logic [3:0] speed;
    logic [2:0] state;
    logic       frame_tick;

    game_ctrl #(
        .SPEED_INIT(4'd2), .SPEED_MAX(4'd3), .RAMP_FRAMES(3), .HIT_CYCLES(4)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .start(start), .pause(pause), .vs(vs),
        .px_dinosaur(px_dinosaur), .px_cactus(px_cactus),
        .game_status(game_status), .game_over(game_over), .speed(speed),
        .state(state), .frame_tick(frame_tick)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // reference model: game state, speed, frames run since game start, overlaps this frame
    int m_st, m_sp, m_frames, m_hit;
    bit m_pend;
    bit hs[4];
    bit hp[4];
    bit hv[4];

    typedef struct {
        bit s;
        bit v;
        bit ov;
        int e_st;
        int e_sp;
        bit e_ft;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_sp = 0; m_frames = 0; m_hit = 0; m_pend = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hs[i] = 1'b0; hp[i] = 1'b0; hv[i] = 1'b1;
        end
    endtask

    // one clock: model sees inputs through a 2-cycle synchronizer delay, then compare
    task automatic cyc();
        bit st_e, pe_e, ft_e, ov, exp_ft;
        @(posedge CLK);
        for (int i = 3; i > 0; i--) begin
            hs[i] = hs[i-1]; hp[i] = hp[i-1]; hv[i] = hv[i-1];
        end
        hs[0] = start; hp[0] = pause; hv[0] = vs;
        st_e = hs[2] & ~hs[3];
        ft_e = ~hv[2] & hv[3];
`ifdef GAME_CTRL_PAUSE_EN
        pe_e = hp[2] & ~hp[3];
`else
        pe_e = 1'b0;
`endif
        ov = px_dinosaur & px_cactus;
        if (m_st == M_IDLE) begin
            if (st_e) m_st = M_ARMED;
        end else if (m_st == M_ARMED) begin
            if (ft_e) begin
                m_st = M_RUN; m_sp = P_INIT; m_frames = 0; m_hit = 0;
            end
        end else if (m_st == M_RUN) begin
            if (ov && (m_hit + 1 >= P_HIT)) begin
                m_st = M_OVER;
            end else if (pe_e) begin
                m_st = M_PAUSE; m_hit = 0; m_pend = 1'b0;
            end else if (ft_e) begin
                m_hit = int'(ov);
                m_frames++;
                if (m_frames % P_RAMP == 0) m_sp = (m_sp + 1 > P_MAX) ? P_MAX : m_sp + 1;
            end else begin
                m_hit += int'(ov);
            end
        end else if (m_st == M_PAUSE) begin
            if (m_pend && ft_e) begin
                m_st = M_RUN; m_pend = 1'b0;
            end else if (pe_e) begin
                m_pend = 1'b1;
            end
        end else if (m_st == M_OVER) begin
            if (st_e) m_st = M_ARMED;
        end
        exp_ft = ~hv[1] & hv[2];
        #1;
        chk("state", state, m_st);
        chk("speed", speed, (m_st == M_IDLE) ? 0 : m_sp);
        chk("game_status", game_status, m_st == M_RUN);
        chk("game_over", game_over, m_st == M_OVER);
        chk("frame_tick", frame_tick, exp_ft);
    endtask

    task automatic step(input bit s, input bit p, input bit v, input bit d, input bit c);
        start = s; pause = p; vs = v; px_dinosaur = d; px_cactus = c;
        cyc();
    endtask

    task automatic frame(input int len);
        step(0, 0, 0, 0, 0);
        repeat (len - 1) step(0, 0, 1, 0, 0);
    endtask

    initial begin
        tbl[0]  = '{1, 1, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 1, 0, 0};
        tbl[3]  = '{0, 0, 0, 1, 0, 0};
        tbl[4]  = '{0, 1, 0, 1, 0, 1};
        tbl[5]  = '{0, 1, 0, 2, 2, 0};
        tbl[6]  = '{0, 1, 0, 2, 2, 0};
        tbl[7]  = '{0, 1, 1, 2, 2, 0};
        tbl[8]  = '{0, 1, 1, 2, 2, 0};
        tbl[9]  = '{0, 1, 1, 2, 2, 0};
        tbl[10] = '{0, 1, 0, 2, 2, 0};

        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_state", state, 0);
        chk("rst_speed", speed, 0);
        chk("rst_frame_tick", frame_tick, 0);
        chk("rst_status", {game_status, game_over}, 0);
        @(negedge CLK);
        RESET_N = 1'b1;

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].s, 0, tbl[i].v, tbl[i].ov, tbl[i].ov);
            chk("tbl_state", state, tbl[i].e_st);
            chk("tbl_speed", speed, tbl[i].e_sp);
            chk("tbl_frame_tick", frame_tick, tbl[i].e_ft);
        end

        // frame tick clears a partial overlap count; 3 more overlaps survive
        frame(8);
        repeat (3) step(0, 0, 1, 1, 1);
        step(0, 0, 1, 0, 0);
        chk("no_collide_3", state, 2);
        frame(8);
        frame(8);
        chk("ramp_speed3", speed, 3);
        repeat (6) frame(8);
        chk("saturate", speed, 3);

        repeat (3) step(0, 0, 1, 1, 1);
        chk("collide_3rd", game_status, 1);
        step(0, 0, 1, 1, 1);
        chk("collide_4th", game_over, 1);
        chk("collide_speed", speed, 3);
        frame(6);
        chk("over_frozen", speed, 3);

        step(1, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("restart_armed", state, 1);
        frame(8);
        chk("restart_run", state, 2);
        chk("restart_speed", speed, 2);

        // tick and the 4th overlap land on the same edge
        step(0, 0, 1, 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 1, 1, 1);
        step(0, 0, 1, 1, 1);
        chk("coincident_over", state, 4);

        step(1, 0, 1, 0, 0);
        repeat (3) step(0, 0, 1, 0, 0);
        frame(8);
        repeat (3) frame(8);
        chk("pre_pause_speed", speed, 3);
        step(0, 1, 1, 0, 0);
        repeat (3) step(0, 0, 1, 0, 0);
`ifdef GAME_CTRL_PAUSE_EN
        chk("pause_state", state, 3);
        chk("pause_status", game_status, 0);
        frame(8);
        chk("pause_hold", state, 3);
        step(0, 1, 1, 0, 0);
        repeat (3) step(0, 0, 1, 0, 0);
        frame(8);
        chk("resume_state", state, 2);
        chk("resume_speed", speed, 3);
`else
        chk("pause_ignored", state, 2);
        chk("pause_ignored_status", game_status, 1);
`endif

        // asynchronous reset in the middle of a collision count
        frame(8);
        repeat (2) step(0, 0, 1, 1, 1);
        px_dinosaur = 1'b0; px_cactus = 1'b0;
        #2 RESET_N = 1'b0;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_speed", speed, 0);
        chk("async_rst_status", game_status, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        model_reset();
        RESET_N = 1'b1;
        repeat (3) frame(6);
        chk("post_rst_idle", state, 0);

        // randomized traffic with a free-running vsync of random period
        begin
            int per = 20;
            int ph = 0;
            for (int n = 0; n < 3000; n++) begin
                bit s, p, d, c;
                s = ($urandom_range(0, 39) == 0);
                p = ($urandom_range(0, 29) == 0);
                d = ($urandom_range(0, 2) == 0);
                c = ($urandom_range(0, 2) == 0);
                step(s, p, (ph != 0), d, c);
                ph++;
                if (ph >= per) begin
                    ph = 0;
                    per = $urandom_range(8, 30);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
